// File: rtl/dw_pkg.sv
// Shared lane geometry for the depthwise requantise datapath.
package dw_pkg;

  localparam int unsigned DW_NUM_PE    = 16;
  localparam int unsigned DW_IN_WIDTH  = 32;
  localparam int unsigned DW_OUT_WIDTH = 8;

  // Low bit index of a lane inside a flattened lane vector.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dw_requant_lane.sv
// One lane: round-half-up arithmetic right shift, optional ReLU, saturate to OUT_WIDTH.
module dw_requant_lane
  import dw_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DW_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DW_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  acc_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_i,
  output logic [OUT_WIDTH-1:0] res_o
);

  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  localparam logic signed [IN_WIDTH:0] ONE  = {{IN_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

  logic signed [IN_WIDTH:0] ext;
  logic signed [IN_WIDTH:0] rnd;
  logic signed [IN_WIDTH:0] sum;
  logic signed [IN_WIDTH:0] shifted;

  always_comb begin
    ext = {acc_i[IN_WIDTH-1], acc_i};
    rnd = '0;
    if (shift_i != '0) rnd = ONE << (shift_i - 5'd1);
    sum     = ext + rnd;
    shifted = sum >>> shift_i;
    if (relu_i && shifted[IN_WIDTH]) shifted = '0;
    if (shifted > MAXV)      res_o = MAXV[OUT_WIDTH-1:0];
    else if (shifted < MINV) res_o = MINV[OUT_WIDTH-1:0];
    else                     res_o = shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/dw_requant_collector.sv
// Collects accumulator vectors, requantises every lane, and buffers results in a
// first-word-fall-through FIFO with ready/valid on both sides.
module dw_requant_collector
  import dw_pkg::*;
#(
  parameter int unsigned NUM_PE     = DW_NUM_PE,
  parameter int unsigned IN_WIDTH   = DW_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DW_OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  input  logic [NUM_PE*IN_WIDTH-1:0]    Result,
  input  logic [4:0]                    shift_amt,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_PE*OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          overflow_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned VW = NUM_PE * OUT_WIDTH;

  logic [VW-1:0] lanes_d;
  logic [VW-1:0] pipe_data_q;
  logic          pipe_valid_q;
  logic [VW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q;
  logic          accept, push, pop;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    dw_requant_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .acc_i  (Result[lane_lo(i, IN_WIDTH) +: IN_WIDTH]),
      .shift_i(shift_amt),
      .relu_i (relu_en),
      .res_o  (lanes_d[lane_lo(i, OUT_WIDTH) +: OUT_WIDTH])
    );
  end

  // Counting the pipe stage as occupied guarantees every registered vector has a slot.
  assign acc_ready = (occ_q + {{AW{1'b0}}, pipe_valid_q}) < (AW+1)'(FIFO_DEPTH);
  assign accept    = acc_valid && acc_ready;
  assign push      = pipe_valid_q;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;
  assign overflow_err = ovf_q;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pipe_valid_q <= accept;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
      if (acc_valid && !acc_ready) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pipe_data_q <= lanes_d;
    if (push)   mem_q[wr_ptr_q] <= pipe_data_q;
  end

endmodule

// File: tb/tb_dw_requant_collector.sv
// Self-checking bench: directed lane cases plus randomized traffic against a queue model.
module tb_dw_requant_collector;

  localparam int unsigned NPE = 16;
  localparam int unsigned IW  = 32;
  localparam int unsigned OW  = 8;
  localparam int unsigned FD  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              acc_valid;
  logic              acc_ready;
  logic [NPE*IW-1:0] Result;
  logic [4:0]        shift_amt;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic [NPE*OW-1:0] out_data;
  logic [2:0]        occupancy;
  logic              overflow_err;

  dw_requant_collector #(
    .NUM_PE(NPE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .Result(Result), .shift_amt(shift_amt), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NPE*OW-1:0] data;
    int                vis;
  } entry_t;

  entry_t q[$];
  int     cyc = 0;
  bit     ovf_m = 1'b0;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_lane(input logic [IW-1:0] x, input int sh, input bit relu);
    longint v;
    v = longint'($signed(x));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[OW-1:0];
  endfunction

  function automatic logic [NPE*OW-1:0] ref_vec(input logic [NPE*IW-1:0] r, input int sh, input bit relu);
    logic [NPE*OW-1:0] o;
    for (int i = 0; i < NPE; i++) o[i*OW +: OW] = ref_lane(r[i*IW +: IW], sh, relu);
    return o;
  endfunction

  function automatic logic [NPE*IW-1:0] rand_vec();
    logic [NPE*IW-1:0] v;
    logic [IW-1:0]     l;
    for (int i = 0; i < NPE; i++) begin
      l = $urandom();
      v[i*IW +: IW] = IW'($signed(l) >>> $urandom_range(0, 31));
    end
    return v;
  endfunction

  function automatic int model_occ();
    int n = 0;
    foreach (q[i]) if (q[i].vis <= cyc) n++;
    return n;
  endfunction

  // Check outputs for the current cycle, then advance one clock and update the model.
  task automatic cycle();
    int  occ_m;
    bit  rdy_m, acc, drop, pop;
    logic [NPE*OW-1:0] exp_d;
    occ_m = model_occ();
    rdy_m = (q.size() < FD);
    chk("acc_ready", acc_ready, rdy_m);
    chk("out_valid", out_valid, occ_m != 0);
    chk("occupancy", occupancy, occ_m);
    chk("overflow_err", overflow_err, ovf_m);
    if (occ_m != 0) chk("out_data", out_data, q[0].data);
    acc   = acc_valid && rdy_m;
    drop  = acc_valid && !rdy_m;
    pop   = (occ_m != 0) && out_ready;
    exp_d = ref_vec(Result, shift_amt, relu_en);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{data: exp_d, vis: cyc + 2});
    if (drop) ovf_m = 1'b1;
    cyc++;
  endtask

  task automatic send_one(input logic [NPE*IW-1:0] v, input int sh, input bit relu);
    Result = v; shift_amt = 5'(sh); relu_en = relu;
    acc_valid = 1'b1; out_ready = 1'b0;
    cycle();
    acc_valid = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  logic [NPE*IW-1:0] v;

  initial begin
    reset = 1'b0; acc_valid = 1'b0; out_ready = 1'b0;
    Result = '0; shift_amt = '0; relu_en = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occupancy", occupancy, 3'd0);
    chk("rst_overflow", overflow_err, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_ready", acc_ready, 1'b1);

    // Directed lane values; out_valid must appear two cycles after accept.
    v = rand_vec();
    v[0*IW +: IW] = 32'd1000;
    v[1*IW +: IW] = -32'sd1000;
    send_one(v, 3, 1'b0);
    chk("lat_n2_valid", out_valid, 1'b1);
    chk("lane0_1000_s3", out_data[0*OW +: OW], 8'd125);
    chk("lane1_m1000_s3", out_data[1*OW +: OW], 8'h83);
    pop_one();

    v = rand_vec();
    v[2*IW +: IW] = 32'd100000;
    send_one(v, 4, 1'b0);
    chk("lane2_sat", out_data[2*OW +: OW], 8'd127);
    pop_one();

    v = rand_vec();
    v[3*IW +: IW] = -32'sd5;
    send_one(v, 0, 1'b1);
    chk("lane3_relu", out_data[3*OW +: OW], 8'd0);
    pop_one();

    v = rand_vec();
    v[0*IW +: IW] = 32'd12;
    v[1*IW +: IW] = -32'sd12;
    send_one(v, 3, 1'b0);
    chk("round_pos_half", out_data[0*OW +: OW], 8'd2);
    chk("round_neg_half", out_data[1*OW +: OW], 8'hFF);
    pop_one();
    cycle();

    // Backpressure: four accepted, fifth dropped, then in-order drain.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Result = rand_vec(); shift_amt = 5'($urandom_range(0, 31)); relu_en = 1'($urandom());
      acc_valid = 1'b1;
      cycle();
      if (i == 3) chk("bp_ready_drop", acc_ready, 1'b0);
    end
    acc_valid = 1'b0;
    chk("bp_overflow_set", overflow_err, 1'b1);
    chk("bp_occ_full", occupancy, 3'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("bp_drained", occupancy, 3'd0);

    // Reset with three vectors buffered clears everything, including sticky overflow.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Result = rand_vec(); shift_amt = 5'($urandom_range(0, 31)); relu_en = 1'($urandom());
      acc_valid = 1'b1;
      cycle();
    end
    acc_valid = 1'b0;
    cycle();
    chk("pre_rst_occ3", occupancy, 3'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_occ", occupancy, 3'd0);
    chk("async_rst_ovf", overflow_err, 1'b0);
    chk("async_rst_data", out_data, '0);
    q.delete();
    ovf_m = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", acc_ready, 1'b1);

    // Streaming: one output per cycle, occupancy never above one.
    out_ready = 1'b1;
    acc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Result = rand_vec(); shift_amt = 5'($urandom_range(0, 31)); relu_en = 1'($urandom());
      cycle();
      chk("stream_occ_le1", occupancy <= 3'd1, 1'b1);
      if (i >= 1) chk("stream_valid", out_valid, 1'b1);
    end
    acc_valid = 1'b0;
    cycle(); cycle();
    chk("stream_no_ovf", overflow_err, 1'b0);

    // Ten vectors with random consumer stalls, wrapping the pointers.
    begin
      int sent = 0;
      for (int budget = 0; budget < 200 && (sent < 10 || q.size() != 0); budget++) begin
        acc_valid = (sent < 10) && (q.size() < FD) && ($urandom_range(0, 3) != 0);
        Result = rand_vec(); shift_amt = 5'($urandom_range(0, 31)); relu_en = 1'($urandom());
        out_ready = 1'($urandom());
        if (acc_valid) sent++;
        cycle();
      end
      chk("wrap_all_sent", 32'(sent), 32'd10);
      chk("wrap_all_drained", 32'(q.size()), 32'd0);
      acc_valid = 1'b0; out_ready = 1'b0;
      cycle();
      chk("wrap_no_ovf", overflow_err, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dw_requant_collector.md
DW_REQUANT_COLLECTOR -- requirements
Module: dw_requant_collector

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 16: lanes per vector.
REQ-002 The block SHALL have parameter IN_WIDTH, default 32: signed accumulator width per lane.
REQ-003 The block SHALL have parameter OUT_WIDTH, default 8: signed output width per lane.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): output buffer entries.
REQ-005 The block SHALL have port clk, input, 1: single clock; all flops rising-edge.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port acc_valid, input, 1: Result holds final accumulations this cycle.
REQ-008 The block SHALL have port acc_ready, output, 1: block can accept a vector.
REQ-009 The block SHALL have port Result, input, NUM_PE*IN_WIDTH: flattened signed sums, lane i at bits [(i+1)*IN_WIDTH-1 : i*IN_WIDTH].
REQ-010 The block SHALL have port shift_amt, input, 5: right-shift amount.
REQ-011 The block SHALL have port relu_en, input, 1: clamp negatives to zero.
REQ-012 The block SHALL have port out_valid, output, 1: out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-014 The block SHALL have port out_data, output, NUM_PE*OUT_WIDTH: flattened requantised lanes, same lane order as Result.
REQ-015 The block SHALL have port occupancy, output, $clog2(FIFO_DEPTH)+1: FIFO entries held.
REQ-016 The block SHALL have port overflow_err, output, 1: sticky flag, set when a vector is dropped.

Function
REQ-017 A vector SHALL be accepted when acc_valid && acc_ready; shift_amt and relu_en SHALL be sampled in the same cycle.
REQ-018 Per lane, the block SHALL compute round-half-up arithmetic right shift, adding 1<<(shift_amt-1) before shifting when shift_amt>0, using IN_WIDTH+1-bit intermediate math with no wrap.
REQ-019 Per lane, relu_en=1 SHALL force negative results to 0.
REQ-020 Per lane, results SHALL saturate to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1], i.e. [-128,127] by default.
REQ-021 The pipeline SHALL be: accept at cycle N, register in pipe stage at N+1, write into FIFO at end of N+1; out_valid SHALL be high at N+2 when the FIFO was empty.
REQ-022 acc_ready SHALL equal (occupancy + pipe_valid) < FIFO_DEPTH, from registered state only, with no combinational path from out_ready.
REQ-023 The FIFO SHALL be first-word-fall-through; out_data SHALL be stable while out_valid && !out_ready.
REQ-024 A pop SHALL occur on out_valid && out_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 acc_valid while !acc_ready SHALL drop the vector and set overflow_err, which SHALL stay set until reset.
REQ-027 out_valid SHALL equal (occupancy != 0).

Reset
REQ-028 While reset=0, the block SHALL clear pipe_valid, pointers, occupancy and overflow_err, and hold out_valid=0 and out_data=0.
REQ-029 After reset, acc_ready SHALL be 1.
REQ-030 Reset asserted mid-transfer SHALL discard all in-flight and buffered vectors.
REQ-031 FIFO storage arrays SHALL need no reset.

Structure
REQ-032 NUM_PE, IN_WIDTH and OUT_WIDTH defaults, together with the lane-slice helper function, SHALL live in shared package dw_pkg.
REQ-033 Per-lane shift/round/ReLU/saturate SHALL be one combinational sub-module, dw_requant_lane, instantiated NUM_PE times by generate.

Verification
REQ-034 The bench SHALL check: lane0=1000, shift=3, relu=0 -> 125; lane1=-1000, shift=3 -> -125; lane2=100000, shift=4 -> 127; lane3=-5, shift=0, relu=1 -> 0.
REQ-035 The bench SHALL check rounding: lane0=12, shift=3 -> 2 (1.5 rounds up), and lane1=-12, shift=3 -> -1.
REQ-036 The bench SHALL check backpressure: with out_ready=0, 4 vectors are accepted and acc_ready drops the cycle after the 4th accept; a 5th acc_valid sets overflow_err; with out_ready=1, the 4 vectors pop in order.
REQ-037 The bench SHALL check streaming: acc_valid=1 every cycle with out_ready=1 -> one output per cycle, first at N+2, occupancy <=1, overflow_err=0.
REQ-038 The bench SHALL check reset: asserting reset with occupancy=3 -> out_valid=0, occupancy=0 and overflow_err=0 asynchronously, and acc_ready=1 after release.
REQ-039 The bench SHALL check wrap: 10 vectors with random out_ready -> in-order data and no loss across pointer wrap.
